// File: rtl/battle_hp_arbiter.sv
// Shared HP-update engine: round-robin arbitration between the player and AI sequencers,
// one saturating add/subtract per four-cycle operation, and sticky dead flags.
module battle_hp_arbiter #(
  parameter int HP_W       = 8,
  parameter int P_HP_MAX   = 100,
  parameter int AI_HP_INIT = 100,
  parameter int HEAL_AMT   = 20
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            p_req,
  input  logic [1:0]      p_op,
  input  logic [HP_W-1:0] p_amt,
  output logic            p_grant,
  input  logic            ai_req,
  input  logic [HP_W-1:0] ai_amt,
  output logic            ai_grant,
  output logic            busy,
  output logic            done,
  output logic [HP_W-1:0] p_hp,
  output logic [HP_W-1:0] ai_hp,
  output logic            p_dead,
  output logic            ai_dead,
  output logic            last_src
);

  // state   | meaning
  // S_IDLE  | sample requests, arbitrate, capture operands
  // S_GRANT | operands settled; HP result registered on leaving
  // S_APPLY | new HP visible; dead flags and done registered on leaving
  // S_CHECK | done pulse visible; return to idle
  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_APPLY, S_CHECK} state_t;

  localparam logic [HP_W-1:0] P_MAX     = HP_W'(P_HP_MAX);
  localparam logic [HP_W-1:0] AI_INIT   = HP_W'(AI_HP_INIT);
  localparam logic [HP_W:0]   P_MAX_EXT = (HP_W+1)'(P_HP_MAX);
  localparam logic [HP_W:0]   HEAL_EXT  = (HP_W+1)'(HEAL_AMT);

  localparam logic [1:0] OP_ATTACK = 2'b00;
  localparam logic [1:0] OP_HEAL   = 2'b11;

  state_t          state_q, state_d;
  logic [HP_W-1:0] p_hp_q, p_hp_d, ai_hp_q, ai_hp_d, amt_q, amt_d;
  logic [1:0]      op_q, op_d;
  logic            src_q, src_d, last_src_q, last_src_d;
  logic            p_dead_q, p_dead_d, ai_dead_q, ai_dead_d;
  logic            p_grant_q, p_grant_d, ai_grant_q, ai_grant_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic [HP_W:0]   heal_sum;
  logic            win_ai;

  always_comb begin
    state_d    = state_q;
    p_hp_d     = p_hp_q;
    ai_hp_d    = ai_hp_q;
    amt_d      = amt_q;
    op_d       = op_q;
    src_d      = src_q;
    last_src_d = last_src_q;
    p_dead_d   = p_dead_q;
    ai_dead_d  = ai_dead_q;
    p_grant_d  = 1'b0;
    ai_grant_d = 1'b0;
    done_d     = 1'b0;
    heal_sum   = {1'b0, p_hp_q} + HEAL_EXT;
    // On a tie the source that did not win last time takes the slot.
    win_ai     = ai_req && (!p_req || !last_src_q);

    unique case (state_q)
      S_IDLE: begin
        if (!p_dead_q && !ai_dead_q && (p_req || ai_req)) begin
          src_d      = win_ai;
          last_src_d = win_ai;
          op_d       = win_ai ? OP_ATTACK : p_op;
          amt_d      = win_ai ? ai_amt : p_amt;
          p_grant_d  = !win_ai;
          ai_grant_d = win_ai;
          state_d    = S_GRANT;
        end
      end
      S_GRANT: begin
        state_d = S_APPLY;
        if (src_q) begin
          p_hp_d = (amt_q >= p_hp_q) ? '0 : p_hp_q - amt_q;
        end else begin
          case (op_q)
            OP_ATTACK: ai_hp_d = (amt_q >= ai_hp_q) ? '0 : ai_hp_q - amt_q;
            OP_HEAL:   p_hp_d  = (heal_sum > P_MAX_EXT) ? P_MAX : heal_sum[HP_W-1:0];
            default:   ;
          endcase
        end
      end
      S_APPLY: begin
        state_d   = S_CHECK;
        done_d    = 1'b1;
        p_dead_d  = p_dead_q  || (p_hp_q == '0);
        ai_dead_d = ai_dead_q || (ai_hp_q == '0);
      end
      S_CHECK: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      state_d    = S_IDLE;
      p_hp_d     = P_MAX;
      ai_hp_d    = AI_INIT;
      p_dead_d   = 1'b0;
      ai_dead_d  = 1'b0;
      last_src_d = 1'b1;
      p_grant_d  = 1'b0;
      ai_grant_d = 1'b0;
      done_d     = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      p_hp_q     <= P_MAX;
      ai_hp_q    <= AI_INIT;
      amt_q      <= '0;
      op_q       <= '0;
      src_q      <= 1'b0;
      last_src_q <= 1'b1;
      p_dead_q   <= 1'b0;
      ai_dead_q  <= 1'b0;
      p_grant_q  <= 1'b0;
      ai_grant_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      p_hp_q     <= p_hp_d;
      ai_hp_q    <= ai_hp_d;
      amt_q      <= amt_d;
      op_q       <= op_d;
      src_q      <= src_d;
      last_src_q <= last_src_d;
      p_dead_q   <= p_dead_d;
      ai_dead_q  <= ai_dead_d;
      p_grant_q  <= p_grant_d;
      ai_grant_q <= ai_grant_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign p_grant  = p_grant_q;
  assign ai_grant = ai_grant_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign p_hp     = p_hp_q;
  assign ai_hp    = ai_hp_q;
  assign p_dead   = p_dead_q;
  assign ai_dead  = ai_dead_q;
  assign last_src = last_src_q;

endmodule

// File: tb/tb_battle_hp_arbiter.sv
// Bench for battle_hp_arbiter: directed scenarios plus random operations checked
// against a transaction-level model of HP, dead flags and round-robin fairness.
module tb_battle_hp_arbiter;

  localparam int HP_MAX = 100;
  localparam int AI_INIT = 100;
  localparam int HEAL = 20;

  logic       clk = 1'b0;
  logic       reset, load, p_req, ai_req;
  logic [1:0] p_op;
  logic [7:0] p_amt, ai_amt;
  logic       p_grant, ai_grant, busy, done, p_dead, ai_dead, last_src;
  logic [7:0] p_hp, ai_hp;

  int checks = 0;
  int errors = 0;

  int m_p, m_ai, m_last;
  bit m_pd, m_ad;

  battle_hp_arbiter #(.HP_W(8), .P_HP_MAX(HP_MAX), .AI_HP_INIT(AI_INIT), .HEAL_AMT(HEAL)) dut (
    .clk(clk), .reset(reset), .load(load),
    .p_req(p_req), .p_op(p_op), .p_amt(p_amt), .p_grant(p_grant),
    .ai_req(ai_req), .ai_amt(ai_amt), .ai_grant(ai_grant),
    .busy(busy), .done(done), .p_hp(p_hp), .ai_hp(ai_hp),
    .p_dead(p_dead), .ai_dead(ai_dead), .last_src(last_src)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_init();
    m_p = HP_MAX; m_ai = AI_INIT; m_last = 1; m_pd = 0; m_ad = 0;
  endfunction

  task automatic check_idle_state(input string tag);
    chk({tag, "_p_hp"}, int'(p_hp), m_p);
    chk({tag, "_ai_hp"}, int'(ai_hp), m_ai);
    chk({tag, "_p_dead"}, int'(p_dead), int'(m_pd));
    chk({tag, "_ai_dead"}, int'(ai_dead), int'(m_ad));
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_last_src"}, int'(last_src), m_last);
  endtask

  task automatic do_load();
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    model_init();
    check_idle_state("load");
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge where the next request may be posed.
  task automatic do_op(input bit pr, input logic [1:0] po, input int pa, input bit ar, input int aa);
    bit any;
    int src;
    bit old_pd, old_ad;
    p_req = pr; p_op = po; p_amt = 8'(pa); ai_req = ar; ai_amt = 8'(aa);
    @(negedge clk);
    any = (pr || ar) && !m_pd && !m_ad;
    src = (pr && ar) ? (m_last == 1 ? 0 : 1) : (ar ? 1 : 0);
    p_req = 1'b0; ai_req = 1'b0;
    p_op = 2'($urandom); p_amt = 8'($urandom); ai_amt = 8'($urandom);
    chk("p_grant", int'(p_grant), int'(any && src == 0));
    chk("ai_grant", int'(ai_grant), int'(any && src == 1));
    chk("busy_grant", int'(busy), int'(any));
    if (!any) begin
      chk("ignored_p_hp", int'(p_hp), m_p);
      chk("ignored_ai_hp", int'(ai_hp), m_ai);
      return;
    end
    m_last = src;
    chk("last_src", int'(last_src), m_last);
    if (src == 1) m_p = (aa >= m_p) ? 0 : m_p - aa;
    else if (po == 2'b00) m_ai = (pa >= m_ai) ? 0 : m_ai - pa;
    else if (po == 2'b11) m_p = (m_p + HEAL > HP_MAX) ? HP_MAX : m_p + HEAL;
    old_pd = m_pd; old_ad = m_ad;
    @(negedge clk);
    chk("apply_p_hp", int'(p_hp), m_p);
    chk("apply_ai_hp", int'(ai_hp), m_ai);
    chk("apply_done", int'(done), 0);
    chk("apply_p_dead_lag", int'(p_dead), int'(old_pd));
    chk("apply_grant_low", int'(p_grant | ai_grant), 0);
    m_pd = m_pd || (m_p == 0);
    m_ad = m_ad || (m_ai == 0);
    @(negedge clk);
    chk("check_done", int'(done), 1);
    chk("check_busy", int'(busy), 1);
    chk("check_p_dead", int'(p_dead), int'(m_pd));
    chk("check_ai_dead", int'(ai_dead), int'(m_ad));
    @(negedge clk);
    chk("end_done", int'(done), 0);
    chk("end_busy", int'(busy), 0);
  endtask

  initial begin
    int gt[$];
    int gs[$];
    reset = 1'b1; load = 1'b0; p_req = 1'b0; ai_req = 1'b0;
    p_op = 2'b00; p_amt = '0; ai_amt = '0;
    model_init();

    // Reset with both requests held; the tie sequence starts on release.
    p_req = 1'b1; ai_req = 1'b1; p_op = 2'b01;
    repeat (2) @(negedge clk);
    check_idle_state("reset");
    chk("reset_p_grant", int'(p_grant), 0);
    chk("reset_ai_grant", int'(ai_grant), 0);
    reset = 1'b0;
    for (int c = 1; c <= 20 && gt.size() < 4; c++) begin
      @(negedge clk);
      if (p_grant) begin gt.push_back(c); gs.push_back(0); end
      if (ai_grant) begin gt.push_back(c); gs.push_back(1); end
    end
    p_req = 1'b0; ai_req = 1'b0;
    chk("tie_grant_count", gt.size(), 4);
    for (int i = 0; i < gt.size(); i++) begin
      chk("tie_order", gs[i], i % 2);
      if (i > 0) chk("tie_spacing", gt[i] - gt[i-1], 4);
    end
    repeat (3) @(negedge clk);
    chk("tie_end_busy", int'(busy), 0);
    do_load();

    do_op(1, 2'b00, 30, 0, 0);
    chk("attack_ai_hp_70", int'(ai_hp), 70);
    do_op(0, 2'b00, 0, 1, 10);
    do_op(1, 2'b11, 0, 0, 0);
    chk("heal_clamp_100", int'(p_hp), 100);
    do_op(0, 2'b00, 0, 1, 50);
    do_op(1, 2'b11, 0, 0, 0);
    chk("heal_70", int'(p_hp), 70);
    do_op(1, 2'b01, 0, 0, 0);
    do_op(1, 2'b00, 0, 0, 0);

    do_load();
    do_op(0, 2'b00, 0, 1, 200);
    chk("kill_p_hp_0", int'(p_hp), 0);
    chk("kill_p_dead", int'(p_dead), 1);
    do_op(1, 2'b00, 10, 0, 0);
    p_req = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("dead_no_grant", int'(p_grant), 0);
      chk("dead_not_busy", int'(busy), 0);
    end
    p_req = 1'b0;

    // Load lands in the APPLY cycle of an AI attack.
    do_load();
    ai_req = 1'b1; ai_amt = 8'd40;
    @(negedge clk);
    ai_req = 1'b0;
    chk("mid_ai_grant", int'(ai_grant), 1);
    @(negedge clk);
    chk("mid_p_hp_60", int'(p_hp), 60);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    model_init();
    check_idle_state("mid_load");
    do_op(1, 2'b01, 0, 1, 5);

    for (int n = 0; n < 120; n++) begin
      if ((m_pd || m_ad) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 15) == 0))
        do_load();
      else
        do_op(1'($urandom), 2'($urandom), int'($urandom_range(0, 60)),
              1'($urandom), int'($urandom_range(0, 60)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
